multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Parametrised multicycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks. It sits between the instruction register opcode field and the shared-ALU/shared-memory datapath. It adds a memory ready handshake, illegal-opcode detection and an instruction-retire pulse.

Parameters:
OPCODE_W, 6, opcode field width.
OP_RTYPE, 6'b000000, R-type opcode.
OP_LW, 6'b100011, load word.
OP_SW, 6'b101011, store word.
OP_BEQ, 6'b000100, branch if equal.
OP_BNE, 6'b000101, branch if not equal (only with BNE_EN).
OP_ADDI, 6'b001000, add immediate.
OP_J, 6'b000010, jump.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  IR[31:26]; sampled in DECODE
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (branch)
BranchNE  out  1  1 = condition is !zero, 0 = condition is zero
IorD  out  1  0 = PC address, 1 = ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  writeback source is MDR
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct
PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset:
  - One clock, synchronous, active-high; the reset polarity and synchronicity are fixed.
  - While reset=1, every output is 0 and state_o=0, regardless of state.
  - On the first edge with reset=0, state is FETCH (encoding 0).
  - Reset asserted mid-instruction aborts it; no write strobe is asserted in that cycle.
- Outputs are a pure function of the state register (Moore), with these exceptions:
  - IRWrite, PCWrite and instr_done qualified by mem_ready where stated.
  - illegal_op decoded from opcode in DECODE.
- States, asserted outputs and next state (any output not listed is 0):
  - FETCH(0): MemRead, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite and PCWrite only when mem_ready. Next: DECODE if mem_ready, else stay.
  - DECODE(1): ALUSrcB=11, ALUOp=00. Next by opcode:
    - RTYPE -> EXECUTE; LW or SW -> MEMADR; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
    - Any other opcode: illegal_op=1, instr_done=1, next FETCH.
  - MEMADR(2): ALUSrcA, ALUSrcB=10. Next: MEMRD if LW, MEMWR if SW. The opcode is latched in DECODE into an internal register; later states use the latched value, not the live input.
  - MEMRD(3): MemRead, IorD. Next: MEMWB if mem_ready, else stay.
  - MEMWB(4): RegWrite, MemtoReg, RegDst=0, instr_done. Next FETCH.
  - MEMWR(5): MemWrite, IorD; instr_done when mem_ready. Next: FETCH if mem_ready, else stay.
  - EXECUTE(6): ALUSrcA, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - ALUWB(7): RegWrite, RegDst=1, instr_done. Next FETCH.
  - BRANCH(8): ALUSrcA, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSrc=01, instr_done; BranchNE=1 when the latched opcode is BNE. Next FETCH.
  - ADDIEX(9): ALUSrcA, ALUSrcB=10, ALUOp=00. Next ADDIWB.
  - ADDIWB(10): RegWrite, RegDst=0, instr_done. Next FETCH.
  - JUMP(11): PCWrite, PCSrc=10, instr_done. Next FETCH.
  - Encodings 12-15 are unreachable; if entered, all outputs are 0 and next state is FETCH.
- Latency with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2. Each wait cycle on mem_ready adds one cycle.
- mem_ready in a state without a memory access is ignored.
- MemRead and MemWrite are never high in the same cycle.

Optional Feature:
BNE_EN: when defined, opcode OP_BNE decodes to BRANCH with BranchNE=1. When undefined, OP_BNE is illegal (illegal_op pulse, back to FETCH) and BranchNE is tied to 0.

Test Plan:
- Reset and fetch: reset=1 for 2 cycles -> all outputs 0. Release with mem_ready=1 -> cycle 1 FETCH with MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01; state_o=1 next cycle.
- LW, fetch not stalled: opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4. RegWrite=1 and MemtoReg=1 only in state 4; instr_done single pulse at instruction cycle 7.
- SW and R-type: 101011 -> states 0,1,2,5, MemWrite=1 in state 5 only. 000000 -> 0,1,6,7, ALUOp=10 in state 6, RegDst=1 and RegWrite=1 in state 7.
- Branches (same opcodes as the existing decoder test): 000100 -> 0,1,8 with PCWriteCond=1, BranchNE=0, ALUOp=01. 000101 -> BranchNE=1 with BNE_EN, illegal_op pulse without it.
- Illegal opcodes 000111, 000110 and 000001 -> illegal_op=1 in DECODE, no write strobe asserted, back to FETCH. Then 000010 -> state 11 with PCWrite=1, PCSrc=10.
- Reset mid-MEMWR with mem_ready=0 -> MemWrite drops in the reset cycle; FETCH on the following cycle.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional macro BNE_EN enables OP_BNE decoding to the BRANCH state with BranchNE=1.
`timescale 1ns/1ps
module multicycle_control_fsm #(
    parameter int                  OPCODE_W      = 6,
    parameter logic [OPCODE_W-1:0] OP_RTYPE      = 6'b000000,
    parameter logic [OPCODE_W-1:0] OP_LW         = 6'b100011,
    parameter logic [OPCODE_W-1:0] OP_SW         = 6'b101011,
    parameter logic [OPCODE_W-1:0] OP_BEQ        = 6'b000100,
    parameter logic [OPCODE_W-1:0] OP_BNE        = 6'b000101,
    parameter logic [OPCODE_W-1:0] OP_ADDI       = 6'b001000,
    parameter logic [OPCODE_W-1:0] OP_J          = 6'b000010,
    parameter bit                  MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSrc,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [3:0]          state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t              r_state;
    logic [OPCODE_W-1:0] r_opcode;

    state_t w_dec_next;
    logic   w_dec_illegal;
    logic   w_ready;

    assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Opcode decode used only while in DECODE; unsupported opcodes return to FETCH.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_dec_next    = S_FETCH;
        w_dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE:     w_dec_next = S_EXECUTE;
            OP_LW, OP_SW: w_dec_next = S_MEMADR;
            OP_BEQ:       w_dec_next = S_BRANCH;
            OP_ADDI:      w_dec_next = S_ADDIEX;
            OP_J:         w_dec_next = S_JUMP;
`ifdef BNE_EN
            OP_BNE:       w_dec_next = S_BRANCH;
`else
            OP_BNE:       w_dec_illegal = 1'b1;
`endif
            default:      w_dec_illegal = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates land together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            case (r_state)
                S_FETCH:   if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_opcode <= opcode;
                    r_state  <= w_dec_next;
                end
                S_MEMADR:  r_state <= (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (w_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (w_ready) r_state <= S_FETCH;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the state register only; reset forces all of them low.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSrc       = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        state_o     = 4'd0;
        if (!reset) begin
            state_o = r_state;
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_ready;
                    PCWrite = w_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = w_dec_illegal;
                    instr_done = w_dec_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = w_ready;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                    instr_done  = 1'b1;
`ifdef BNE_EN
                    BranchNE    = (r_opcode == OP_BNE);
`endif
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm: per-cycle state and output vectors.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;

    int n_pass  = 0;
    int n_total = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .instr_done(instr_done), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Field order: PCWrite PCWriteCond BranchNE IorD MemRead MemWrite IRWrite MemtoReg
    //              RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSrc instr_done illegal_op
    wire [18:0] w_outs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                          MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                          instr_done, illegal_op};

    localparam logic [18:0] V_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] V_FETCH_R = 19'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] V_FETCH_W = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [18:0] V_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [18:0] V_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [18:0] V_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [18:0] V_MEMRD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] V_MEMWB   = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [18:0] V_MEMWR_R = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [18:0] V_MEMWR_W = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [18:0] V_EXECUTE = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [18:0] V_ALUWB   = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [18:0] V_BEQ     = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [18:0] V_BNE     = 19'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [18:0] V_ADDIEX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [18:0] V_ADDIWB  = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [18:0] V_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [5:0]  GARBAGE   = 6'b111111;

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (state_o !== 4'd0 || w_outs !== V_ZERO)
                $display("FAIL reset[%0d]: state_o=%0d outs=%b, required state_o=0 outs=%b", i, state_o, w_outs, V_ZERO);
            else n_pass++;
        end
        reset = 1'b0;
        #1;
        n_total++;
        if (state_o !== 4'd0 || w_outs !== V_FETCH_R)
            $display("FAIL reset_release: state_o=%0d outs=%b, required state_o=0 outs=%b", state_o, w_outs, V_FETCH_R);
        else n_pass++;
    endtask

    // LW with two MEMRD wait cycles; mem_ready low in MEMADR must be ignored.
    task automatic test_lw();
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        logic        rd[$] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < st.size(); i++) begin
            opcode = (i <= 1) ? 6'b100011 : GARBAGE;
            mem_ready = rd[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL lw[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    // SW with one stalled fetch cycle and one MEMWR wait cycle.
    task automatic test_sw();
        logic [3:0]  st[$] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic [18:0] ov[$] = '{V_FETCH_W, V_FETCH_R, V_DECODE, V_MEMADR, V_MEMWR_W, V_MEMWR_R};
        logic        rd[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < st.size(); i++) begin
            opcode = (i <= 2) ? 6'b101011 : GARBAGE;
            mem_ready = rd[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL sw[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    // R-type then ADDI back to back; mem_ready low outside memory states is ignored.
    task automatic test_rtype_addi();
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd9, 4'd10};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DECODE, V_EXECUTE, V_ALUWB,
                               V_FETCH_R, V_DECODE, V_ADDIEX, V_ADDIWB};
        logic [5:0]  op[$] = '{6'b000000, 6'b000000, GARBAGE, GARBAGE,
                               6'b001000, 6'b001000, GARBAGE, GARBAGE};
        logic        rd[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < st.size(); i++) begin
            opcode = op[i];
            mem_ready = rd[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL rtype_addi[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
`ifdef BNE_EN
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DECODE, V_BEQ, V_FETCH_R, V_DECODE, V_BNE};
        logic [5:0]  op[$] = '{6'b000100, 6'b000100, GARBAGE, 6'b000101, 6'b000101, GARBAGE};
`else
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DECODE, V_BEQ, V_FETCH_R, V_DEC_ILL};
        logic [5:0]  op[$] = '{6'b000100, 6'b000100, GARBAGE, 6'b000101, 6'b000101};
`endif
        mem_ready = 1'b1;
        for (int i = 0; i < st.size(); i++) begin
            opcode = op[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL branch[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    // Three illegal opcodes, each a 2-cycle instruction, followed by a jump.
    task automatic test_illegal_jump();
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd11};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DEC_ILL, V_FETCH_R, V_DEC_ILL, V_FETCH_R, V_DEC_ILL,
                               V_FETCH_R, V_DECODE, V_JUMP};
        logic [5:0]  op[$] = '{6'b000111, 6'b000111, 6'b000110, 6'b000110, 6'b000001, 6'b000001,
                               6'b000010, 6'b000010, GARBAGE};
        mem_ready = 1'b1;
        for (int i = 0; i < st.size(); i++) begin
            opcode = op[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL illegal_jump[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    // Reset arrives while a store is waiting in MEMWR.
    task automatic test_reset_mid();
        logic [3:0]  st[$] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0};
        logic [18:0] ov[$] = '{V_FETCH_R, V_DECODE, V_MEMADR, V_MEMWR_W, V_ZERO, V_FETCH_R};
        logic        rs[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        rd[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < st.size(); i++) begin
            opcode = (i <= 1) ? 6'b101011 : GARBAGE;
            reset = rs[i];
            mem_ready = rd[i];
            #1;
            n_total++;
            if (state_o !== st[i] || w_outs !== ov[i])
                $display("FAIL reset_mid[%0d]: state_o=%0d outs=%b, required state_o=%0d outs=%b", i, state_o, w_outs, st[i], ov[i]);
            else n_pass++;
            if (i == 3) begin
                // Still in MEMWR: reset must pull MemWrite low in this same cycle.
                reset = 1'b1;
                #1;
                n_total++;
                if (MemWrite !== 1'b0 || w_outs !== V_ZERO)
                    $display("FAIL reset_mid_strobe: MemWrite=%b outs=%b, required MemWrite=0 outs=%b", MemWrite, w_outs, V_ZERO);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_addi();
        test_branch();
        test_illegal_jump();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
